pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_skid_reg.sv | 22 ++
 rtl/pipe_stage_buf.sv | 127 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffer: buffer state encoding and
// the payload field layout (pc_4 | instruction | A | B | redirect_ctrl).
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 32;
  localparam int REG_W   = 32;
  localparam int REDIR_W = 4;

  // Field offsets, LSB first: redirect_ctrl, B, A, instruction, pc_4.
  localparam int REDIR_OFF = 0;
  localparam int B_OFF     = REDIR_OFF + REDIR_W;
  localparam int A_OFF     = B_OFF + REG_W;
  localparam int INSTR_OFF = A_OFF + REG_W;
  localparam int PC_OFF    = INSTR_OFF + INSTR_W;
  localparam int PAYLOAD_W = PC_OFF + PC_W;

endpackage

// File: rtl/pipe_skid_reg.sv
// Second payload slot used by the buffer when PIPE_SKID_EN is defined.
// Clear wins over load so a flush never leaves a stale payload behind.
module pipe_skid_reg #(
  parameter int DATA_W = 112
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// One-entry pipeline stage buffer with flush and a saturating stall counter.
// Define PIPE_SKID_EN to add a skid slot and a registered in_ready.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 112,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt,
  output state_t            state
);

  // Handshake: a transfer happens on any rising edge where valid && ready are
  // both high; valid never waits on ready, and out_data is the main register.

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              xfer_in, xfer_out;
  logic              skid_load;
  logic [DATA_W-1:0] skid_data;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;
  assign state     = state_q;
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_valid && out_ready;

`ifdef PIPE_SKID_EN
  logic ready_q;

  // Ready comes straight from a flop so no combinational path crosses the stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= (state_d != ST_SKID);
    end
  end

  assign in_ready = ready_q;

  pipe_skid_reg #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .load  (skid_load),
    .d     (in_data),
    .q     (skid_data)
  );
`else
  assign in_ready  = !out_valid || out_ready;
  assign skid_data = '0;
`endif

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_load = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (xfer_in) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (xfer_in && xfer_out) begin
            main_d = in_data;
          end else if (xfer_out) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end else if (xfer_in) begin
            // Only reachable with a skid slot; ready is low here otherwise.
            state_d   = ST_SKID;
            skid_load = 1'b1;
          end
        end
`ifdef PIPE_SKID_EN
        ST_SKID: begin
          if (xfer_out) begin
            state_d = ST_FULL;
            main_d  = skid_data;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf with hand-computed expectations; covers the
// default build and, when PIPE_SKID_EN is defined, the skid path.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int DATA_W = 112;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  stall_cnt;
  state_t            state;

  int checks;
  int failures;
  logic [DATA_W-1:0] exp_q[$];

  pipe_stage_buf #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stall_cnt (stall_cnt),
    .state     (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    #1;
  endtask

  // Scoreboard: expected payloads in order; pop and compare on each out transfer.
  task automatic expect_out(input string tag);
    logic [DATA_W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_data"}, out_data, e);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    step();
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_cnt", stall_cnt, '0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_state", state, ST_EMPTY);
    rst_n = 1'b1;

    // Streaming: 1,2,3 each appear one edge after being presented.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, DATA_W'(i), 1'b1, 1'b0);
      exp_q.push_back(DATA_W'(i));
      step();
      expect_out($sformatf("stream%0d", i));
    end
    check("stream_cnt", stall_cnt, 4'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("drain_valid", out_valid, 1'b0);
    check("drain_data", out_data, '0);

    // Backpressure: 0xA held while 0xB waits.
    drive(1'b1, DATA_W'('hA), 1'b0, 1'b0);
    exp_q.push_back(DATA_W'('hA));
    step();
    check("bp_a_data", out_data, DATA_W'('hA));
`ifdef PIPE_SKID_EN
    check("bp_ready_full", in_ready, 1'b1);
    drive(1'b1, DATA_W'('hB), 1'b0, 1'b0);
    exp_q.push_back(DATA_W'('hB));
    step();
    check("bp_state_skid", state, ST_SKID);
    check("bp_ready_skid", in_ready, 1'b0);
    check("bp_cnt1", stall_cnt, 4'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    check("bp_cnt2", stall_cnt, 4'd2);
    check("bp_hold_a", out_data, DATA_W'('hA));
    drive(1'b0, '0, 1'b1, 1'b0);
    expect_out("bp_out_a");
    step();
    expect_out("bp_out_b");
    step();
`else
    drive(1'b1, DATA_W'('hB), 1'b0, 1'b0);
    check("bp_ready_low", in_ready, 1'b0);
    step();
    check("bp_cnt1", stall_cnt, 4'd1);
    check("bp_hold_a", out_data, DATA_W'('hA));
    step();
    check("bp_cnt2", stall_cnt, 4'd2);
    drive(1'b1, DATA_W'('hB), 1'b1, 1'b0);
    check("bp_ready_comb", in_ready, 1'b1);
    expect_out("bp_out_a");
    exp_q.push_back(DATA_W'('hB));
    step();
    expect_out("bp_pass_b");
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
`endif
    check("bp_empty", out_valid, 1'b0);
    check("bp_cnt_keep", stall_cnt, 4'd2);

    // Flush with a simultaneous input: 0x55 is dropped, bubble is zero.
    drive(1'b1, DATA_W'('h11), 1'b0, 1'b0);
    step();
    check("fl_load", out_data, DATA_W'('h11));
    drive(1'b1, DATA_W'('h55), 1'b0, 1'b1);
    step();
    check("fl_valid", out_valid, 1'b0);
    check("fl_data", out_data, '0);
    check("fl_cnt_kept", stall_cnt, 4'd3);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("fl_no55_valid", out_valid, 1'b0);
    check("fl_no55_data", out_data, '0);

    // Saturation: 3 + 20 stall cycles clamps at 15.
    drive(1'b1, DATA_W'('h77), 1'b0, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt", stall_cnt, 4'd15);
    check("sat_hold", out_data, DATA_W'('h77));

    // Reset while stalled discards the held entry.
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_cnt", stall_cnt, 4'd0);
    check("mid_rst_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_data", out_data, '0);
    check("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
